ntt_stage_sched: RTL and testbench
==================================

Name: ntt_stage_sched

Overview:
- Sequences the NWC/NTT datapath: memory_top bank reads, twiddle requests to TF_top, and write-back of butterfly results, stage by stage.
- Issues one row (all BN banks at a single address) per cycle and tracks in-flight rows through a fixed-latency butterfly pipeline.
- Drains between stages to prevent read-after-write hazards.
- Raises done when all stages complete; replaces the free-running sequencing currently embedded in top.

Parameters:
- MA, 64: addresses per bank (rows per stage).
- STAGES, 3: number of stage passes (k+1 iterations).
- PIPE_LAT, 8: cycles from rd_en to the matching wr_en (memory read plus butterfly latency); must be >= 1.
- AW, $clog2(MA): address width.
- SW, $clog2(STAGES) (min 1): stage index width.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a transform; sampled only in IDLE or DONE.
- stall, input, 1: blocks issue of a new row this cycle.
- busy, output, 1: high from the first ISSUE cycle through the final write-back.
- done, output, 1: high in DONE state; held until the next accepted start.
- rd_en, output, 1: memory row read strobe.
- rd_addr, output, AW: row address being read.
- rd_stage, output, SW: stage index of the current read.
- tf_req, output, 1: twiddle request; equal to rd_en.
- tf_idx, output, AW: twiddle row index; equal to rd_addr.
- wr_en, output, 1: write-back strobe.
- wr_addr, output, AW: write-back row address.
- wr_stage, output, SW: stage index of the write-back.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE; every output 0; address/stage counters 0; delay line cleared. Applies mid-operation; in-flight writes are discarded.
- States: IDLE, ISSUE, DRAIN, NEXT, DONE.
  - IDLE/DONE: start=1 leads to ISSUE, with stage=0 and addr=0; done clears in that transition cycle.
  - ISSUE, stall=0: rd_en=tf_req=1, rd_addr=addr, addr++. After the row with addr=MA-1, go to DRAIN.
  - ISSUE, stall=1: rd_en=0; addr holds; the delay line keeps advancing, so a bubble propagates.
  - DRAIN: no reads. When the in-flight count is 0 and no write is pending, go to NEXT if stage<STAGES-1, else DONE.
  - NEXT: one cycle; stage++, addr=0, then ISSUE.
- Write path:
  - PIPE_LAT-deep shift register of {valid, addr, stage}.
  - wr_en/wr_addr/wr_stage equal the rd_en/rd_addr/rd_stage values from exactly PIPE_LAT cycles earlier.
  - Write order equals read order.
- In-flight counter: +1 on rd_en, -1 on wr_en, both in the same cycle give net 0. Range 0..PIPE_LAT.
- Timing without stall, start high in cycle 0:
  - Reads in cycles 1..MA; writes in cycles 1+PIPE_LAT..MA+PIPE_LAT.
  - NEXT (or DONE) in cycle MA+PIPE_LAT+1; stage period is MA+PIPE_LAT+1.
  - done first high in cycle STAGES*(MA+PIPE_LAT+1).
- busy = state in {ISSUE, DRAIN, NEXT}. busy and done are never both 1.
- start while busy: ignored. start held high in DONE: restarts immediately (done low for the next cycle).
- stall during DRAIN/NEXT/IDLE: no effect.
- Address wrap: addr never exceeds MA-1; it is reset to 0 only in NEXT or on start.

Test Plan:
- Reset/idle: rst=0 with clk running, then rst=1 with start=0 for 20 cycles: all outputs 0; state IDLE.
- Nominal run (MA=64, PIPE_LAT=8, STAGES=3), start pulse in cycle 0:
  - 192 rd_en and 192 wr_en in total, rd_addr ascending 0..63 in each stage.
  - First wr_en in cycle 9 with wr_addr=0.
  - done rises in cycle 219; busy falls in the same cycle.
- Stall insertion: stall=1 for cycles 10–14 of stage 0:
  - 5 rd_en gaps; rd_addr resumes at 9; matching wr_en gaps appear 8 cycles later.
  - done delayed to cycle 224; no address skipped or duplicated.
- Stage boundary hazard: check every stage-1 read occurs after the stage-0 write with wr_addr=63 (cycle 72) plus one NEXT cycle, i.e. first stage-1 rd_en in cycle 74.
- start while busy: start pulses at cycles 30 and 150: no restart; counters are unaffected. start in DONE: a new run begins and done drops one cycle later.
- Reset mid-operation: rst=0 at cycle 100:
  - All outputs 0 asynchronously, before the next clock edge.
  - No wr_en after release of reset.
  - A subsequent start completes a full run with done at +219 cycles.

Source files
------------

// File: rtl/ntt_stage_sched_if.sv
// ntt_stage_sched_if: control/strobe bundle between the NTT scheduler
// and the memory, twiddle and write-back datapath.
//   start/stall   : requester -> scheduler
//   busy/done     : scheduler status
//   rd_* / tf_*   : row read and twiddle request
//   wr_*          : row write-back
interface ntt_stage_sched_if #(
   parameter int AW = 6,
   parameter int SW = 2
);
   logic          start;
   logic          stall;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [SW-1:0] rd_stage;
   logic          tf_req;
   logic [AW-1:0] tf_idx;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [SW-1:0] wr_stage;

   modport master (
      output start, stall,
      input  busy, done,
      input  rd_en, rd_addr, rd_stage,
      input  tf_req, tf_idx,
      input  wr_en, wr_addr, wr_stage
   );

   modport slave (
      input  start, stall,
      output busy, done,
      output rd_en, rd_addr, rd_stage,
      output tf_req, tf_idx,
      output wr_en, wr_addr, wr_stage
   );
endinterface

// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: stage-by-stage NTT row sequencer. Issues one row
// read (plus twiddle request) per cycle, delays each read by PIPE_LAT
// cycles to form the write-back, drains between stages, flags done.
// Ports: clk, rst (async active-low), bus (slave modport):
//   start/stall in; busy/done, rd_*/tf_*, wr_* out (all registered).
module ntt_stage_sched #(
   parameter int MA       = 64,
   parameter int STAGES   = 3,
   parameter int PIPE_LAT = 8,
   parameter int AW       = $clog2(MA),
   parameter int SW       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic           clk,
   input  logic           rst,
   ntt_stage_sched_if.slave bus
);

   localparam int CW = $clog2(PIPE_LAT + 1) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_NEXT,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [SW-1:0] stage_q, stage_d;
   logic          all_q, all_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          iss;
   logic [AW-1:0] iss_addr;
   logic [SW-1:0] iss_stage;

   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [SW-1:0] rd_stage_q, rd_stage_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          dl_v_q [PIPE_LAT];
   logic [AW-1:0] dl_a_q [PIPE_LAT];
   logic [SW-1:0] dl_s_q [PIPE_LAT];

   logic          wr_en_w;

   assign wr_en_w = dl_v_q[PIPE_LAT-1];

   // Rows in flight after this edge; zero means the last
   // write-back of the stage is the one leaving now.
   assign cnt_d = cnt_q + CW'(rd_en_q) - CW'(wr_en_w);

   // Next-state: the issue decision is made one cycle ahead so
   // the registered read strobe lines up with the ISSUE state.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      stage_d   = stage_q;
      all_d     = all_q;
      iss       = 1'b0;
      iss_addr  = addr_q;
      iss_stage = stage_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d   = S_ISSUE;
               stage_d   = '0;
               iss       = 1'b1;
               iss_addr  = '0;
               iss_stage = '0;
            end
         end
         S_ISSUE: begin
            if (all_q) begin
               state_d = S_DRAIN;
            end else if (!bus.stall) begin
               iss = 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_d == '0) begin
               if (stage_q == SW'(STAGES - 1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end
         S_NEXT: begin
            state_d   = S_ISSUE;
            stage_d   = stage_q + SW'(1);
            iss       = 1'b1;
            iss_addr  = '0;
            iss_stage = stage_q + SW'(1);
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Address saturates on the last row; the flag ends issue.
      if (iss) begin
         if (iss_addr == AW'(MA - 1)) begin
            addr_d = iss_addr;
            all_d  = 1'b1;
         end else begin
            addr_d = iss_addr + AW'(1);
            all_d  = 1'b0;
         end
      end
   end

   always_comb begin
      rd_en_d    = iss;
      rd_addr_d  = iss ? iss_addr : rd_addr_q;
      rd_stage_d = iss ? iss_stage : rd_stage_q;
      busy_d     = (state_d == S_ISSUE) ||
                   (state_d == S_DRAIN) ||
                   (state_d == S_NEXT);
      done_d     = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         stage_q    <= '0;
         all_q      <= 1'b0;
         cnt_q      <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         rd_stage_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            dl_v_q[i] <= 1'b0;
            dl_a_q[i] <= '0;
            dl_s_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         stage_q    <= stage_d;
         all_q      <= all_d;
         cnt_q      <= cnt_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         rd_stage_q <= rd_stage_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         dl_v_q[0]  <= rd_en_q;
         dl_a_q[0]  <= rd_addr_q;
         dl_s_q[0]  <= rd_stage_q;
         for (int i = 1; i < PIPE_LAT; i++) begin
            dl_v_q[i] <= dl_v_q[i-1];
            dl_a_q[i] <= dl_a_q[i-1];
            dl_s_q[i] <= dl_s_q[i-1];
         end
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.rd_en    = rd_en_q;
   assign bus.rd_addr  = rd_addr_q;
   assign bus.rd_stage = rd_stage_q;
   assign bus.tf_req   = rd_en_q;
   assign bus.tf_idx   = rd_addr_q;
   assign bus.wr_en    = wr_en_w;
   assign bus.wr_addr  = dl_a_q[PIPE_LAT-1];
   assign bus.wr_stage = dl_s_q[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_stage_sched.sv
// tb_ntt_stage_sched: directed bench for ntt_stage_sched
// (MA=64, STAGES=3, PIPE_LAT=8).
module tb_ntt_stage_sched;

   logic clk;
   logic rst_n;

   ntt_stage_sched_if #(.AW(6), .SW(2)) bus ();

   ntt_stage_sched #(
      .MA(64), .STAGES(3), .PIPE_LAT(8)
   ) dut (
      .clk(clk),
      .rst(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   int n_rd, n_wr, ord_err, both_err;
   int done_cyc, busy_fall;
   int first_wr_cyc, first_wr_addr, last_wr_s0;
   int first_rd [3];
   bit rd_h   [0:511];
   bit wr_h   [0:511];
   bit done_h [0:511];
   int ra_h   [0:511];

   task automatic tick();
      @(negedge clk);
   endtask

   // Starts a transform at the current (negedge) cycle 0 and
   // observes every cycle until done rises or maxc expires.
   // Reads and writes are scored against an in-order model.
   task automatic run(input int slo, input int shi,
                      input int sa, input int sb,
                      input int maxc);
      int ea, es, wa, ws;
      bit pb;
      n_rd = 0; n_wr = 0; ord_err = 0; both_err = 0;
      done_cyc = -1; busy_fall = -1;
      first_wr_cyc = -1; first_wr_addr = -1; last_wr_s0 = -1;
      for (int k = 0; k < 3; k++) first_rd[k] = -1;
      ea = 0; es = 0; wa = 0; ws = 0; pb = 1'b0;
      for (int c = 0; c <= maxc; c++) begin
         rd_h[c]   = bus.rd_en;
         wr_h[c]   = bus.wr_en;
         done_h[c] = bus.done;
         ra_h[c]   = int'(bus.rd_addr);
         if (bus.rd_en) begin
            n_rd++;
            if (es < 3 && first_rd[es] < 0) first_rd[es] = c;
            if (int'(bus.rd_addr) != ea || int'(bus.rd_stage) != es)
               ord_err++;
            if (bus.tf_req !== 1'b1 || bus.tf_idx !== bus.rd_addr)
               ord_err++;
            if (ea == 63) begin ea = 0; es++; end
            else ea++;
         end else if (bus.tf_req !== 1'b0) begin
            ord_err++;
         end
         if (bus.wr_en) begin
            n_wr++;
            if (first_wr_cyc < 0) begin
               first_wr_cyc  = c;
               first_wr_addr = int'(bus.wr_addr);
            end
            if (bus.wr_stage == 2'd0 && bus.wr_addr == 6'd63)
               last_wr_s0 = c;
            if (int'(bus.wr_addr) != wa || int'(bus.wr_stage) != ws)
               ord_err++;
            if (wa == 63) begin wa = 0; ws++; end
            else wa++;
         end
         if (bus.busy && bus.done) both_err++;
         if (c > 0 && pb && !bus.busy && busy_fall < 0)
            busy_fall = c;
         pb = bus.busy;
         if (c > 0 && bus.done && done_cyc < 0) done_cyc = c;
         if (done_cyc >= 0) break;
         bus.start = (c == 0) || (c == sa) || (c == sb);
         bus.stall = (c >= slo) && (c <= shi);
         tick();
      end
      bus.start = 1'b0;
      bus.stall = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      repeat (3) tick();
      checks++;
      if ({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.tf_req} !== 5'b0
          || bus.rd_addr !== 6'd0 || bus.wr_addr !== 6'd0) begin
         errors++;
         $display("FAIL reset_hold: outputs busy=%b done=%b rd=%b wr=%b want 0",
                  bus.busy, bus.done, bus.rd_en, bus.wr_en);
      end
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if ({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.tf_req} !== 5'b0
             || bus.rd_addr !== 6'd0 || bus.wr_addr !== 6'd0
             || bus.rd_stage !== 2'd0 || bus.wr_stage !== 2'd0)
            bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL idle_outputs: %0d nonzero cycles want 0", bad);
      end
   endtask

   task automatic test_nominal();
      run(-1, -2, -1, -1, 400);
      checks++;
      if (n_rd !== 192) begin
         errors++; $display("FAIL nom_rd_count: got %0d want 192", n_rd);
      end
      checks++;
      if (n_wr !== 192) begin
         errors++; $display("FAIL nom_wr_count: got %0d want 192", n_wr);
      end
      checks++;
      if (ord_err !== 0) begin
         errors++; $display("FAIL nom_order: got %0d errs want 0", ord_err);
      end
      checks++;
      if (first_rd[0] !== 1) begin
         errors++; $display("FAIL nom_first_rd: got %0d want 1", first_rd[0]);
      end
      checks++;
      if (first_wr_cyc !== 9 || first_wr_addr !== 0) begin
         errors++;
         $display("FAIL nom_first_wr: got cyc %0d addr %0d want 9/0",
                  first_wr_cyc, first_wr_addr);
      end
      checks++;
      if (done_cyc !== 219) begin
         errors++; $display("FAIL nom_done: got %0d want 219", done_cyc);
      end
      checks++;
      if (busy_fall !== 219) begin
         errors++; $display("FAIL nom_busy_fall: got %0d want 219", busy_fall);
      end
      checks++;
      if (both_err !== 0) begin
         errors++; $display("FAIL nom_busy_done: got %0d want 0", both_err);
      end
   endtask

   task automatic test_stage_boundary();
      run(-1, -2, -1, -1, 400);
      checks++;
      if (last_wr_s0 !== 72) begin
         errors++; $display("FAIL bnd_last_wr0: got %0d want 72", last_wr_s0);
      end
      checks++;
      if (first_rd[1] !== 74) begin
         errors++; $display("FAIL bnd_first_rd1: got %0d want 74", first_rd[1]);
      end
      checks++;
      if (first_rd[2] !== 147) begin
         errors++; $display("FAIL bnd_first_rd2: got %0d want 147", first_rd[2]);
      end
   endtask

   task automatic test_stall();
      int gaps;
      // Stall sampled in cycles 9..13 blanks the reads of 10..14.
      run(9, 13, -1, -1, 400);
      gaps = 0;
      for (int c = 10; c <= 14; c++) if (rd_h[c]) gaps++;
      for (int c = 18; c <= 22; c++) if (wr_h[c]) gaps++;
      checks++;
      if (gaps !== 0) begin
         errors++; $display("FAIL stall_gaps: got %0d strobes want 0", gaps);
      end
      checks++;
      if (!rd_h[9] || ra_h[9] !== 8 || !rd_h[15] || ra_h[15] !== 9) begin
         errors++;
         $display("FAIL stall_resume: got addr %0d/%0d want 8/9",
                  ra_h[9], ra_h[15]);
      end
      checks++;
      if (!wr_h[17] || !wr_h[23]) begin
         errors++;
         $display("FAIL stall_wr_edges: got %b/%b want 1/1",
                  wr_h[17], wr_h[23]);
      end
      checks++;
      if (done_cyc !== 224) begin
         errors++; $display("FAIL stall_done: got %0d want 224", done_cyc);
      end
      checks++;
      if (n_rd !== 192 || n_wr !== 192 || ord_err !== 0) begin
         errors++;
         $display("FAIL stall_seq: got rd %0d wr %0d errs %0d want 192/192/0",
                  n_rd, n_wr, ord_err);
      end
   endtask

   task automatic test_start_busy();
      run(-1, -2, 30, 150, 400);
      checks++;
      if (done_cyc !== 219) begin
         errors++; $display("FAIL sbusy_done: got %0d want 219", done_cyc);
      end
      checks++;
      if (n_rd !== 192 || n_wr !== 192 || ord_err !== 0) begin
         errors++;
         $display("FAIL sbusy_seq: got rd %0d wr %0d errs %0d want 192/192/0",
                  n_rd, n_wr, ord_err);
      end
   endtask

   task automatic test_restart();
      // Entered with the previous run sitting in DONE.
      run(-1, -2, -1, -1, 400);
      checks++;
      if (done_h[0] !== 1'b1 || done_h[1] !== 1'b0) begin
         errors++;
         $display("FAIL restart_done: got %b->%b want 1->0",
                  done_h[0], done_h[1]);
      end
      checks++;
      if (!rd_h[1] || ra_h[1] !== 0) begin
         errors++;
         $display("FAIL restart_rd: got en %b addr %0d want 1/0",
                  rd_h[1], ra_h[1]);
      end
      checks++;
      if (done_cyc !== 219) begin
         errors++; $display("FAIL restart_period: got %0d want 219", done_cyc);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (99) tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.rd_en !== 1'b1 || bus.rd_addr !== 6'd26) begin
         errors++;
         $display("FAIL mid_active: got busy %b rd %b addr %0d want 1/1/26",
                  bus.busy, bus.rd_en, bus.rd_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.tf_req} !== 5'b0
          || bus.rd_addr !== 6'd0 || bus.wr_addr !== 6'd0) begin
         errors++;
         $display("FAIL mid_async: got busy %b rd %b wr %b want 0",
                  bus.busy, bus.rd_en, bus.wr_en);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.wr_en || bus.rd_en || bus.busy || bus.done) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL mid_no_wr: got %0d active cycles want 0", bad);
      end
      run(-1, -2, -1, -1, 400);
      checks++;
      if (done_cyc !== 219 || n_wr !== 192 || ord_err !== 0) begin
         errors++;
         $display("FAIL mid_rerun: got done %0d wr %0d errs %0d want 219/192/0",
                  done_cyc, n_wr, ord_err);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      test_reset();
      test_nominal();
      test_stage_boundary();
      test_stall();
      test_start_busy();
      test_restart();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
